riscv_mdu_issue: RTL

Issue sequencer between decode/dispatch and the RV64M multiply/divide unit. It buffers M-extension requests in a small FIFO and launches them one at a time into the MDU. It captures the one-cycle `mdu_valid` result pulse into a holding register and presents it to writeback over a valid/ready handshake. It also handles pipeline flush, including discarding an MDU operation already in flight, because the MDU cannot be aborted.

---
 rtl/riscv_mdu_pkg.sv | 34 +++
 rtl/riscv_mdu_issue_if.sv | 50 +++++
 rtl/riscv_mdu_req_fifo.sv | 73 +++++++
 rtl/riscv_mdu_issue.sv | 129 ++++++++++++
 4 files changed

// File: rtl/riscv_mdu_pkg.sv
// rtl/riscv_mdu_pkg.sv - shared types and constants for the MDU issue sequencer
//
// Purpose: M-extension funct3 codes, the queued request record and the
// issue FSM state encoding, shared by the FIFO, the top and the bench.
// Ports: none (package).
package riscv_mdu_pkg;

  localparam int MDU_XLEN = 64;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef struct packed {
    logic [2:0]          funct3;
    logic                is_32bit;
    logic [MDU_XLEN-1:0] rs1;
    logic [MDU_XLEN-1:0] rs2;
    logic [4:0]          rd;
  } mdu_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mdu_issue_state_e;

endpackage

// File: rtl/riscv_mdu_issue_if.sv
// rtl/riscv_mdu_issue_if.sv - request, MDU and writeback signal bundle
//
// Purpose: groups the three handshakes of the MDU issue sequencer.
// Ports (signals):
//   req_*  : dispatch -> sequencer request (valid/ready)
//   mdu_*  : sequencer <-> MDU (enable pulse out, valid pulse + result in)
//   wb_*   : sequencer -> writeback result (valid/ready)
// Modports: slave = the sequencer, master = its environment.
interface riscv_mdu_issue_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic            req_is_32bit;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [4:0]      req_rd;

  logic            mdu_enable;
  logic [2:0]      mdu_funct3;
  logic            mdu_is_32bit;
  logic [XLEN-1:0] mdu_rs1;
  logic [XLEN-1:0] mdu_rs2;
  logic [XLEN-1:0] mdu_result;
  logic            mdu_valid;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  req_valid, req_funct3, req_is_32bit, req_rs1, req_rs2, req_rd,
    output req_ready,
    output mdu_enable, mdu_funct3, mdu_is_32bit, mdu_rs1, mdu_rs2,
    input  mdu_result, mdu_valid,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready
  );

  modport master (
    output req_valid, req_funct3, req_is_32bit, req_rs1, req_rs2, req_rd,
    input  req_ready,
    input  mdu_enable, mdu_funct3, mdu_is_32bit, mdu_rs1, mdu_rs2,
    output mdu_result, mdu_valid,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/riscv_mdu_req_fifo.sv
// rtl/riscv_mdu_req_fifo.sv - DEPTH-entry FIFO of pending MDU requests
//
// Purpose: in-order buffer of mdu_req_t between dispatch and the issue FSM.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   clear         : synchronous empty (pipeline flush), beats push/pop
//   push, din     : write one entry (ignored when full)
//   pop, dout     : consume head (ignored when empty); dout = head entry
//   full, empty   : occupancy flags
module riscv_mdu_req_fifo
  import riscv_mdu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear,
  input  logic     push,
  input  mdu_req_t din,
  input  logic     pop,
  output mdu_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  mdu_req_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointer wrap works for non-power-of-two depths as well.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/riscv_mdu_issue.sv
// rtl/riscv_mdu_issue.sv - issue sequencer between dispatch and the RV64M MDU
//
// Purpose: queues M-extension requests, launches them one at a time into the
// MDU, captures the one-cycle completion pulse into a result slot presented
// to writeback, and discards an in-flight operation after a flush.
// Ports:
//   clk, rst_n : clock, async active-low reset (shared with the MDU)
//   flush      : synchronous pipeline flush
//   bus        : riscv_mdu_issue_if.slave (req_*, mdu_*, wb_* handshakes)
//   busy       : FIFO non-empty, FSM not IDLE, or result slot occupied
module riscv_mdu_issue
  import riscv_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  riscv_mdu_issue_if.slave  bus,
  output logic              busy
);

  mdu_issue_state_e state;
  mdu_issue_state_e state_nxt;

  mdu_req_t   fifo_din;
  mdu_req_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  logic [4:0]      inflight_rd;
  logic            wb_valid_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  // Requests to x0 are accepted but dropped: they have no architectural effect.
  assign push = bus.req_valid && bus.req_ready && (bus.req_rd != 5'd0);

  assign fifo_din = '{funct3:   bus.req_funct3,
                      is_32bit: bus.req_is_32bit,
                      rs1:      MDU_XLEN'(bus.req_rs1),
                      rs2:      MDU_XLEN'(bus.req_rs2),
                      rd:       bus.req_rd};

  riscv_mdu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // Issue only into an empty result slot so a completion is never lost.
      IDLE:  if (!fifo_empty && !wb_valid_q && !flush) state_nxt = ISSUE;
      ISSUE: state_nxt = flush ? DRAIN : WAIT;
      // A completion arriving with the flush ends the op here; waiting in
      // DRAIN for a second pulse would hang.
      WAIT: begin
        if (bus.mdu_valid) state_nxt = IDLE;
        else if (flush)    state_nxt = DRAIN;
      end
      DRAIN: if (bus.mdu_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mdu_enable   = 1'b0;
    bus.mdu_funct3   = '0;
    bus.mdu_is_32bit = 1'b0;
    bus.mdu_rs1      = '0;
    bus.mdu_rs2      = '0;
    pop              = 1'b0;
    if (state == ISSUE) begin
      bus.mdu_enable   = 1'b1;
      bus.mdu_funct3   = head.funct3;
      bus.mdu_is_32bit = head.is_32bit;
      bus.mdu_rs1      = XLEN'(head.rs1);
      bus.mdu_rs2      = XLEN'(head.rs2);
      pop              = 1'b1;
    end
    bus.req_ready = !fifo_full && (state != DRAIN) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_rd <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      if (state == ISSUE) inflight_rd <= head.rd;
      // Flush drops the slot; a handshake in that cycle already delivered it.
      if (flush) begin
        wb_valid_q <= 1'b0;
      end else if (state == WAIT && bus.mdu_valid) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= inflight_rd;
        wb_data_q  <= bus.mdu_result;
      end else if (wb_valid_q && bus.wb_ready) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

  assign busy = !fifo_empty || (state != IDLE) || wb_valid_q;

endmodule
